// File: rtl/paula_audio_dma_sched_pkg.sv
// Shared constants and types for the Paula audio DMA slot scheduler:
// AUDxDAT register addresses, default slot timing and FSM state encodings.
package paula_audio_dma_sched_pkg;

    localparam logic [7:0] SLOT_OFFSET_DEF = 8'd7;
    localparam logic [7:0] SLOT_STRIDE_DEF = 8'd2;

    // Chip register addresses [8:1]; 0xFF marks "no register" on an idle bus.
    localparam logic [7:0] AUD0DAT  = 8'h55;
    localparam logic [7:0] AUD1DAT  = 8'h5D;
    localparam logic [7:0] AUD2DAT  = 8'h65;
    localparam logic [7:0] AUD3DAT  = 8'h6D;
    localparam logic [7:0] REG_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b11
    } sched_state_t;

    function automatic logic [7:0] aud_dat_addr(input logic [1:0] chan);
        case (chan)
            2'd0:    return AUD0DAT;
            2'd1:    return AUD1DAT;
            2'd2:    return AUD2DAT;
            default: return AUD3DAT;
        endcase
    endfunction

endpackage

// File: rtl/paula_audio_slot_ctr.sv
// Colour-clock counter since the horizontal strobe, decoding which audio
// channel's slot (if any) falls on the current cck.
module paula_audio_slot_ctr
    import paula_audio_dma_sched_pkg::*;
#(
    parameter logic [7:0] SLOT_OFFSET = SLOT_OFFSET_DEF,
    parameter logic [7:0] SLOT_STRIDE = SLOT_STRIDE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       cck,
    input  logic       clear,
    input  logic       run,
    output logic       slot_hit,
    output logic [1:0] slot_idx
);

    logic [7:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset || clear) begin
                cnt <= '0;
            end else if (run && cck && cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // NOTE: both outputs get a default first so no path through the loop
    // leaves them unassigned, which would otherwise infer a latch.
    always_comb begin
        slot_hit = 1'b0;
        slot_idx = 2'd0;
        for (int n = 0; n < 4; n++) begin
            if (run && cck && cnt == SLOT_OFFSET + SLOT_STRIDE * 8'(n)) begin
                slot_hit = 1'b1;
                slot_idx = 2'(n);
            end
        end
    end

endmodule

// File: rtl/paula_audio_dma_sched.sv
// Per-scanline audio DMA slot scheduler: latches channel requests at strhor
// and issues one AUDxDAT fetch per pending channel in its fixed cck slot.
module paula_audio_dma_sched
    import paula_audio_dma_sched_pkg::*;
#(
    parameter logic [7:0] SLOT_OFFSET = SLOT_OFFSET_DEF,
    parameter logic [7:0] SLOT_STRIDE = SLOT_STRIDE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       cck,
    input  logic       strhor,
    input  logic       dmaen,
    input  logic [3:0] auden,
    input  logic [3:0] dmareq,
    input  logic [3:0] dmas,
    output logic [3:0] dmaena,
    output logic       dma_cycle,
    output logic [1:0] dma_chan,
    output logic       dma_reload,
    output logic [7:0] reg_address_out,
    output logic [3:0] pending
);

    sched_state_t state, state_next;
    logic [3:0]   reload_l;
    logic         slot_hit;
    logic [1:0]   slot_idx;
    logic         fetch;
    logic [3:0]   served;

    paula_audio_slot_ctr #(
        .SLOT_OFFSET (SLOT_OFFSET),
        .SLOT_STRIDE (SLOT_STRIDE)
    ) u_slot_ctr (
        .clk      (clk),
        .reset    (reset),
        .clk7_en  (clk7_en),
        .cck      (cck),
        .clear    (strhor),
        .run      (state == COUNT),
        .slot_hit (slot_hit),
        .slot_idx (slot_idx)
    );

    // A new line's strobe pre-empts any slot landing on the same edge.
    assign fetch  = slot_hit && !strhor && pending[slot_idx] && dmaena[slot_idx];
    assign served = fetch ? (4'(1) << slot_idx) : 4'b0000;

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                state <= IDLE;
            end else begin
                state <= state_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (strhor) begin
            state_next = COUNT;
        end else begin
            case (state)
                COUNT:   if (slot_hit && slot_idx == 2'd3) state_next = DONE;
                IDLE,
                DONE:    state_next = state;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                dmaena          <= '0;
                pending         <= '0;
                reload_l        <= '0;
                dma_cycle       <= 1'b0;
                dma_chan        <= 2'd0;
                dma_reload      <= 1'b0;
                reg_address_out <= REG_IDLE;
            end else begin
                dmaena <= {4{dmaen}} & auden;
                if (strhor) begin
                    // Channels drop dmareq on this same edge; we see the pre-edge value.
                    pending         <= dmareq & dmaena;
                    reload_l        <= dmas & dmareq & dmaena;
                    dma_cycle       <= 1'b0;
                    dma_reload      <= 1'b0;
                    reg_address_out <= REG_IDLE;
                end else begin
                    pending  <= pending & dmaena & ~served;
                    reload_l <= reload_l & dmaena & ~served;
                    if (fetch) begin
                        dma_cycle       <= 1'b1;
                        dma_chan        <= slot_idx;
                        dma_reload      <= reload_l[slot_idx];
                        reg_address_out <= aud_dat_addr(slot_idx);
                    end else if (cck) begin
                        dma_cycle       <= 1'b0;
                        dma_reload      <= 1'b0;
                        reg_address_out <= REG_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_paula_audio_dma_sched.sv
// Scoreboard bench: a whole-run stimulus plan is analysed up front by a
// line-level reference model; a monitor matches every DUT fetch against it.
module tb_paula_audio_dma_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, clk7_en, cck, strhor, dmaen;
    logic [3:0] auden, dmareq, dmas;
    logic [3:0] dmaena, pending;
    logic       dma_cycle, dma_reload;
    logic [1:0] dma_chan;
    logic [7:0] reg_address_out;

    paula_audio_dma_sched dut (
        .clk             (clk),
        .reset           (reset),
        .clk7_en         (clk7_en),
        .cck             (cck),
        .strhor          (strhor),
        .dmaen           (dmaen),
        .auden           (auden),
        .dmareq          (dmareq),
        .dmas            (dmas),
        .dmaena          (dmaena),
        .dma_cycle       (dma_cycle),
        .dma_chan        (dma_chan),
        .dma_reload      (dma_reload),
        .reg_address_out (reg_address_out),
        .pending         (pending)
    );

    typedef struct {
        logic       en, ck, str, rst, chk, dmaen;
        logic [3:0] auden, req, dms;
    } stim_t;

    typedef struct {
        int         issue, rise, fall, chan;
        logic       reload;
        logic [7:0] addr;
        logic [3:0] pend, ena;
    } exp_t;

    stim_t      plan[$];
    exp_t       all_exp[$];
    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         edge_idx = -1;
    logic       cur_dmaen = 1'b0;
    logic [3:0] cur_auden = 4'b0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_idx);
        end
    endtask

    function automatic void add(input logic en, ck, str, rst, input logic [3:0] req, dms,
                                input logic chk);
        stim_t s;
        s.en = en; s.ck = ck; s.str = str; s.rst = rst; s.chk = chk;
        s.dmaen = cur_dmaen; s.auden = cur_auden; s.req = req; s.dms = dms;
        plan.push_back(s);
    endfunction

    function automatic void add_idle(input int en_pct);
        add(1'($urandom_range(99) < en_pct), 1'($urandom), 1'b0, 1'b0,
            4'($urandom), 4'($urandom), 1'b0);
    endfunction

    // ev: 0 none, 1 drop auden[ev_arg] once ev_k ccks elapsed,
    //     2 end the line before cck ev_k (caller reissues strhor), 3 reset at cck ev_k.
    function automatic void gen_line(input logic [3:0] req, dms, input int en_pct, ck_pct,
                                     input bit slow, input int ev, ev_k, ev_arg,
                                     input bit pre, input bit str_ck);
        int k = 0;
        int step = 0;
        bit alt = 1'b0;
        logic en, ck;
        if (pre) repeat (2) add_idle(100);
        add(1'b1, str_ck, 1'b1, 1'b0, req, dms, 1'b0);
        while (k < 16) begin
            step++;
            if (ev == 2 && k == ev_k) return;
            if (ev == 3 && k == ev_k) begin
                add(1'b1, 1'b1, 1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'b0);
                add(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'b1);
                repeat (40) add_idle(70);
                return;
            end
            if (ev == 1 && k == ev_k) cur_auden[ev_arg] = 1'b0;
            if (slow) begin
                en = (step % 4 == 0);
                ck = en && alt;
                if (en) alt = !alt;
            end else begin
                en = ($urandom_range(99) < en_pct);
                ck = ($urandom_range(99) < ck_pct);
            end
            add(en, ck, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'b0);
            if (en && ck) k++;
        end
        repeat (2) add_idle(100);
    endfunction

    // Registered enable seen by edge e: DMACON as sampled on the previous enabled edge.
    function automatic logic [3:0] enmask(input int e);
        for (int q = e - 1; q >= 0; q--) begin
            if (plan[q].en) return (plan[q].rst || !plan[q].dmaen) ? 4'b0000 : plan[q].auden;
        end
        return 4'b0000;
    endfunction

    // A latched request survives only if its channel stays enabled on every edge up to t.
    function automatic bit alive(input int m, input int s, input int t);
        logic [3:0] mk;
        for (int e = s + 1; e <= t; e++) begin
            if (plan[e].en) begin
                mk = enmask(e);
                if (!mk[m]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic void model_line(input int s);
        int         end_e;
        int         ck_e[$];
        int         idx;
        logic [3:0] lat, rl;
        exp_t       x;
        end_e = plan.size();
        for (int e = s + 1; e < plan.size(); e++) begin
            if (plan[e].en && (plan[e].str || plan[e].rst)) begin
                end_e = e;
                break;
            end
        end
        for (int e = s + 1; e < end_e; e++) if (plan[e].en && plan[e].ck) ck_e.push_back(e);
        lat = plan[s].req & enmask(s);
        rl  = lat & plan[s].dms;
        for (int n = 0; n < 4; n++) begin
            idx = 7 + 2 * n;
            if (idx < ck_e.size() && lat[n] && alive(n, s, ck_e[idx])) begin
                x.issue  = s;
                x.chan   = n;
                x.reload = rl[n];
                x.addr   = 8'h55 + 8'(8 * n);
                x.rise   = ck_e[idx];
                x.fall   = (idx + 1 < ck_e.size()) ? ck_e[idx + 1] : end_e;
                x.pend   = 4'b0000;
                for (int m = n + 1; m < 4; m++) if (lat[m] && alive(m, s, x.rise)) x.pend[m] = 1'b1;
                x.ena    = plan[x.rise].dmaen ? plan[x.rise].auden : 4'b0000;
                all_exp.push_back(x);
            end
        end
    endfunction

    task automatic check_reset_values();
        check("rst_dmaena", 32'(dmaena), 32'h0);
        check("rst_dma_cycle", 32'(dma_cycle), 32'h0);
        check("rst_dma_chan", 32'(dma_chan), 32'h0);
        check("rst_dma_reload", 32'(dma_reload), 32'h0);
        check("rst_reg_address", 32'(reg_address_out), 32'hFF);
        check("rst_pending", 32'(pending), 32'h0);
    endtask

    // Monitor: every rising dma_cycle must match the oldest outstanding expectation.
    initial begin
        bit   prev = 1'b0;
        exp_t cur;
        int   exp_fall = -1;
        forever begin
            @(negedge clk);
            if (dma_cycle === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dma: chan=%0d addr=%0h at edge %0d, none expected",
                             dma_chan, reg_address_out, edge_idx);
                    exp_fall = -1;
                end else begin
                    cur = sb.pop_front();
                    check("rise_edge", 32'(edge_idx), 32'(cur.rise));
                    check("dma_chan", 32'(dma_chan), 32'(cur.chan));
                    check("dma_reload", 32'(dma_reload), 32'(cur.reload));
                    check("reg_address", 32'(reg_address_out), 32'(cur.addr));
                    check("pending_after", 32'(pending), 32'(cur.pend));
                    check("dmaena", 32'(dmaena), 32'(cur.ena));
                    exp_fall = cur.fall;
                end
            end else if (dma_cycle !== 1'b1 && prev) begin
                check("fall_edge", 32'(edge_idx), 32'(exp_fall));
                check("idle_address", 32'(reg_address_out), 32'hFF);
                check("idle_reload", 32'(dma_reload), 32'h0);
            end
            prev = (dma_cycle === 1'b1);
        end
    end

    initial begin
        int nx = 0;

        // Reset held for three cycles, then two lines with DMA mastered off.
        add(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
        cur_dmaen = 1'b0; cur_auden = 4'hF;
        gen_line(4'hF, 4'hF, 100, 100, 0, 0, 0, 0, 1, 0);
        gen_line(4'hF, 4'hF, 100, 100, 0, 0, 0, 0, 1, 0);
        // Channels 0 and 2, without then with a pointer restart on channel 0.
        cur_dmaen = 1'b1; cur_auden = 4'b0101;
        gen_line(4'b0101, 4'b0000, 100, 100, 0, 0, 0, 0, 1, 0);
        gen_line(4'b0101, 4'b0001, 100, 100, 0, 0, 0, 0, 1, 0);
        // All channels, channel 3 disabled just before its slot.
        cur_auden = 4'hF;
        gen_line(4'hF, 4'b1010, 100, 100, 0, 1, 12, 3, 1, 0);
        // Strobe reissued on the slot-3 cck of a fully pending line.
        cur_auden = 4'hF;
        gen_line(4'hF, 4'hF, 80, 80, 0, 2, 13, 0, 1, 0);
        gen_line(4'b0110, 4'b0100, 80, 80, 0, 0, 0, 0, 0, 1);
        // Quarter-rate clock enable with cck on every second enabled cycle.
        gen_line(4'b1001, 4'b1000, 0, 0, 1, 0, 0, 0, 1, 0);
        // Reset in the middle of a line.
        gen_line(4'hF, 4'h0, 90, 90, 0, 3, 8, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cur_dmaen = ($urandom_range(9) != 0);
            cur_auden = 4'($urandom);
            gen_line(4'($urandom), 4'($urandom), int'($urandom_range(40, 100)),
                     int'($urandom_range(30, 100)), 0, int'($urandom_range(1)),
                     int'($urandom_range(14)), int'($urandom_range(3)), 1, 1'($urandom));
        end
        repeat (4) add_idle(100);

        for (int p = 0; p < plan.size(); p++) begin
            if (plan[p].en && plan[p].str && !plan[p].rst) model_line(p);
        end

        for (int p = 0; p < plan.size(); p++) begin
            clk7_en = plan[p].en;
            cck     = plan[p].ck;
            strhor  = plan[p].str;
            reset   = plan[p].rst;
            dmaen   = plan[p].dmaen;
            auden   = plan[p].auden;
            dmareq  = plan[p].req;
            dmas    = plan[p].dms;
            @(posedge clk);
            edge_idx = p;
            while (nx < all_exp.size() && all_exp[nx].issue == p) begin
                sb.push_back(all_exp[nx]);
                nx++;
            end
            if (plan[p].chk) begin
                @(negedge clk);
                check_reset_values();
            end else begin
                #1;
            end
        end
        clk7_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        check("all_expected_issued", 32'(nx), 32'(all_exp.size()));
        check("pending_end", 32'(pending), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
